uart_rx: RTL and testbench

UART receiver, 8N1, LSB first, sampling at mid-bit on a 12 MHz system clock. Pairs with the design's UART transmitter to give the FPGA a full-duplex serial link to the host. Synchronises the asynchronous RX line and validates start and stop bits. Each frame produces a one-cycle byte-valid pulse or a one-cycle framing-error pulse.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clocking constants and
// the mid-bit offset helper used by the receiver and the transmitter.
package uart_pkg;

    localparam int CLK_FREQ_HZ       = 32'd12_000_000;
    localparam int UART_BAUD_DEFAULT = 32'd9600;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } uart_state_t;

    // Cycles from start-bit detect to the centre of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 32'sd1) / 32'sd2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// selectable reset value so idle-high lines come out of reset idle.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;

    // Metastability flop followed by the output flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r   <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta_r   <= async_in;
            sync_out <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, single mid-bit sample per bit. Emits a
// one-cycle RX_DV with the byte or a one-cycle FRAME_ERR per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_BAUD    = UART_BAUD_DEFAULT,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / UART_BAUD
) (
    input  logic       SER_CLK,
    input  logic       RST,
    input  logic       RX_DATA,
    output logic [7:0] RX_BYTE,
    output logic       RX_DV,
    output logic       FRAME_ERR
);

    localparam logic [31:0] HALF = 32'(half_bit(CLKS_PER_BIT));
    localparam logic [31:0] LAST = 32'(CLKS_PER_BIT - 32'sd1);

    logic        rx_s;
    uart_state_t state_r;
    logic [31:0] clk_count_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        armed_r;
    logic [1:0]  sync_fill_r;

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk      (SER_CLK),
        .rst      (RST),
        .async_in (RX_DATA),
        .sync_out (rx_s)
    );

    // Receiver FSM, bit counters, shift register and output pulses.
    always_ff @(posedge SER_CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            clk_count_r <= 32'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
            armed_r     <= 1'b0;
            sync_fill_r <= 2'b00;
            RX_BYTE     <= 8'd0;
            RX_DV       <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            RX_DV       <= 1'b0;
            FRAME_ERR   <= 1'b0;
            sync_fill_r <= {sync_fill_r[0], 1'b1};
            case (state_r)
                IDLE: begin
                    clk_count_r <= 32'd0;
                    bit_idx_r   <= 3'd0;
                    // The synchroniser holds its reset value for two cycles, so
                    // only a high that really came from the line may arm.
                    if (!armed_r) begin
                        if (rx_s && sync_fill_r[1]) begin
                            armed_r <= 1'b1;
                        end
                    end else if (!rx_s) begin
                        state_r <= START;
                    end
                end
                START: begin
                    if (clk_count_r == HALF) begin
                        clk_count_r <= 32'd0;
                        bit_idx_r   <= 3'd0;
                        state_r     <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_count_r <= clk_count_r + 32'd1;
                    end
                end
                DATA: begin
                    if (clk_count_r == LAST) begin
                        clk_count_r        <= 32'd0;
                        shift_r[bit_idx_r] <= rx_s;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + 32'd1;
                    end
                end
                STOP: begin
                    if (clk_count_r == LAST) begin
                        clk_count_r <= 32'd0;
                        if (rx_s) begin
                            RX_BYTE <= shift_r;
                            RX_DV   <= 1'b1;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                        state_r <= CLEANUP;
                    end else begin
                        clk_count_r <= clk_count_r + 32'd1;
                    end
                end
                CLEANUP: begin
                    // A held-low line (break) parks here after one FRAME_ERR.
                    if (rx_s) begin
                        armed_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: bit-banged frames,
// expected events predicted from frame start times and the bytes sent.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB + 1;

    logic       SER_CLK = 1'b0;
    logic       RST     = 1'b1;
    logic       RX_DATA = 1'b1;
    logic [7:0] RX_BYTE;
    logic       RX_DV;
    logic       FRAME_ERR;

    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    int         dv_cyc[$];
    logic [7:0] dv_byte[$];
    int         fe_cyc[$];
    bit         both_seen;
    int         exp_cyc[$];
    logic [7:0] exp_byte[$];
    int         exp_fe[$];
    logic [7:0] last_good;

    uart_rx #(
        .UART_BAUD    (750000),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .SER_CLK   (SER_CLK),
        .RST       (RST),
        .RX_DATA   (RX_DATA),
        .RX_BYTE   (RX_BYTE),
        .RX_DV     (RX_DV),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 SER_CLK = ~SER_CLK;

    always @(posedge SER_CLK) cyc <= cyc + 1;

    always @(negedge SER_CLK) begin
        if (RX_DV === 1'b1) begin
            dv_cyc.push_back(cyc);
            dv_byte.push_back(RX_BYTE);
        end
        if (FRAME_ERR === 1'b1) fe_cyc.push_back(cyc);
        if (RX_DV === 1'b1 && FRAME_ERR === 1'b1) both_seen = 1'b1;
    end

    task automatic clear_log();
        dv_cyc.delete(); dv_byte.delete(); fe_cyc.delete();
        exp_cyc.delete(); exp_byte.delete(); exp_fe.delete();
        both_seen = 1'b0;
    endtask

    task automatic idle(input int n, input logic v);
        repeat (n) begin
            @(posedge SER_CLK); #1;
            RX_DATA = v;
        end
    endtask

    // One frame; bit length in hundredths of a clock cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int len_x100,
                              output int start_cyc);
        int ncyc;
        ncyc = (10 * len_x100 + 99) / 100;
        for (int t = 0; t < ncyc; t++) begin
            int j;
            j = (t * 100) / len_x100;
            @(posedge SER_CLK); #1;
            if (t == 0) start_cyc = cyc;
            if (j == 0)      RX_DATA = 1'b0;
            else if (j <= 8) RX_DATA = b[j-1];
            else             RX_DATA = stop;
        end
    endtask

    task automatic expect_byte(input int s, input logic [7:0] b);
        exp_cyc.push_back(s + LAT);
        exp_byte.push_back(b);
        last_good = b;
    endtask

    task automatic test_reset();
        @(posedge SER_CLK); #1;
        RST = 1'b1;
        @(posedge SER_CLK);
        @(negedge SER_CLK);
        total++; if (RX_BYTE !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", RX_BYTE); end
        total++; if (RX_DV !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b want 0", RX_DV); end
        total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); end
        @(posedge SER_CLK); #1;
        RST = 1'b0;
        idle(10, 1'b1);
        last_good = 8'h00;
    endtask

    task automatic test_single_byte();
        int s;
        clear_log();
        send_frame(8'hA5, 1'b1, 1600, s);
        expect_byte(s, 8'hA5);
        idle(20, 1'b1);
        total++; if (dv_cyc.size() != 1) begin bad++; $display("FAIL single_dv_count: got %0d want 1", dv_cyc.size()); end
        else begin
            total++; if (dv_byte[0] !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", dv_byte[0]); end
            total++; if (dv_cyc[0] != exp_cyc[0]) begin bad++; $display("FAIL single_latency: got cycle %0d want %0d", dv_cyc[0], exp_cyc[0]); end
        end
        total++; if (fe_cyc.size() != 0) begin bad++; $display("FAIL single_ferr: got %0d pulses want 0", fe_cyc.size()); end
        total++; if (RX_BYTE !== 8'hA5) begin bad++; $display("FAIL single_hold: got %h want a5", RX_BYTE); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [7:0] bytes [3];
        bytes = '{8'h00, 8'hFF, 8'h3C};
        clear_log();
        foreach (bytes[i]) begin
            send_frame(bytes[i], 1'b1, 1600, s);
            expect_byte(s, bytes[i]);
        end
        idle(20, 1'b1);
        total++; if (dv_cyc.size() != 3) begin bad++; $display("FAIL b2b_dv_count: got %0d want 3", dv_cyc.size()); end
        else foreach (exp_cyc[i]) begin
            total++; if (dv_byte[i] !== exp_byte[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, dv_byte[i], exp_byte[i]); end
            total++; if (dv_cyc[i] != exp_cyc[i]) begin bad++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, dv_cyc[i], exp_cyc[i]); end
        end
        total++; if (fe_cyc.size() != 0) begin bad++; $display("FAIL b2b_ferr: got %0d pulses want 0", fe_cyc.size()); end
    endtask

    task automatic test_glitch();
        int s;
        clear_log();
        idle(3, 1'b0);
        idle(30, 1'b1);
        total++; if (dv_cyc.size() + fe_cyc.size() != 0) begin bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", dv_cyc.size() + fe_cyc.size()); end
        send_frame(8'h55, 1'b1, 1600, s);
        expect_byte(s, 8'h55);
        idle(20, 1'b1);
        total++; if (dv_cyc.size() != 1) begin bad++; $display("FAIL glitch_dv_count: got %0d want 1", dv_cyc.size()); end
        else begin
            total++; if (dv_byte[0] !== 8'h55) begin bad++; $display("FAIL glitch_byte: got %h want 55", dv_byte[0]); end
        end
    endtask

    task automatic test_framing_error();
        int s;
        logic [7:0] prev;
        prev = last_good;
        clear_log();
        send_frame(8'h81, 1'b0, 1600, s);
        exp_fe.push_back(s + LAT);
        idle(100, 1'b0);
        idle(30, 1'b1);
        total++; if (fe_cyc.size() != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", fe_cyc.size()); end
        else begin
            total++; if (fe_cyc[0] != exp_fe[0]) begin bad++; $display("FAIL ferr_cycle: got %0d want %0d", fe_cyc[0], exp_fe[0]); end
        end
        total++; if (dv_cyc.size() != 0) begin bad++; $display("FAIL ferr_dv: got %0d pulses want 0", dv_cyc.size()); end
        total++; if (RX_BYTE !== prev) begin bad++; $display("FAIL ferr_hold: got %h want %h", RX_BYTE, prev); end
        send_frame(8'h7E, 1'b1, 1600, s);
        expect_byte(s, 8'h7E);
        idle(20, 1'b1);
        total++; if (dv_cyc.size() != 1) begin bad++; $display("FAIL ferr_next_count: got %0d want 1", dv_cyc.size()); end
        else begin
            total++; if (dv_byte[0] !== 8'h7E) begin bad++; $display("FAIL ferr_next_byte: got %h want 7e", dv_byte[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        logic [7:0] c3;
        c3 = 8'hC3;
        clear_log();
        // Start bit, data bits 0..2 and half of bit 3 (which is low).
        for (int t = 0; t < 4 * CPB + CPB / 2; t++) begin
            @(posedge SER_CLK); #1;
            RX_DATA = (t < CPB) ? 1'b0 : c3[t / CPB - 1];
        end
        @(posedge SER_CLK); #1;
        RST = 1'b1;
        @(posedge SER_CLK);
        @(negedge SER_CLK);
        total++; if (RX_BYTE !== 8'h00 || RX_DV !== 1'b0 || FRAME_ERR !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs: got byte=%h dv=%b ferr=%b want 00/0/0", RX_BYTE, RX_DV, FRAME_ERR);
        end
        @(posedge SER_CLK); #1;
        RST = 1'b0;
        idle(200, 1'b0);
        total++; if (dv_cyc.size() + fe_cyc.size() != 0) begin bad++; $display("FAIL midrst_low_pulse: got %0d pulses want 0", dv_cyc.size() + fe_cyc.size()); end
        idle(20, 1'b1);
        send_frame(8'h12, 1'b1, 1600, s);
        expect_byte(s, 8'h12);
        idle(20, 1'b1);
        total++; if (dv_cyc.size() != 1 || fe_cyc.size() != 0) begin bad++; $display("FAIL midrst_count: got dv=%0d ferr=%0d want 1/0", dv_cyc.size(), fe_cyc.size()); end
        total++; if (RX_BYTE !== 8'h12) begin bad++; $display("FAIL midrst_byte: got %h want 12", RX_BYTE); end
    endtask

    task automatic test_baud_skew();
        int s;
        int lens [2];
        lens = '{1632, 1568};
        clear_log();
        foreach (lens[i]) begin
            send_frame(8'h96, 1'b1, lens[i], s);
            expect_byte(s, 8'h96);
            idle(20, 1'b1);
        end
        total++; if (dv_cyc.size() != 2) begin bad++; $display("FAIL skew_dv_count: got %0d want 2", dv_cyc.size()); end
        else foreach (exp_cyc[i]) begin
            total++; if (dv_byte[i] !== 8'h96) begin bad++; $display("FAIL skew_byte%0d: got %h want 96", i, dv_byte[i]); end
        end
        total++; if (fe_cyc.size() != 0) begin bad++; $display("FAIL skew_ferr: got %0d pulses want 0", fe_cyc.size()); end
    endtask

    task automatic test_random();
        int s;
        logic [7:0] b;
        logic stop;
        clear_log();
        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, 1600, s);
            if (stop) begin
                expect_byte(s, b);
                idle($urandom_range(0, 12), 1'b1);
            end else begin
                exp_fe.push_back(s + LAT);
                idle($urandom_range(8, 20), 1'b1);
            end
        end
        idle(20, 1'b1);
        total++; if (dv_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL rand_dv_count: got %0d want %0d", dv_cyc.size(), exp_cyc.size()); end
        else foreach (exp_cyc[i]) begin
            total++; if (dv_byte[i] !== exp_byte[i]) begin bad++; $display("FAIL rand_byte%0d: got %h want %h", i, dv_byte[i], exp_byte[i]); end
            total++; if (dv_cyc[i] != exp_cyc[i]) begin bad++; $display("FAIL rand_cycle%0d: got %0d want %0d", i, dv_cyc[i], exp_cyc[i]); end
        end
        total++; if (fe_cyc.size() != exp_fe.size()) begin bad++; $display("FAIL rand_ferr_count: got %0d want %0d", fe_cyc.size(), exp_fe.size()); end
        total++; if (RX_BYTE !== last_good) begin bad++; $display("FAIL rand_hold: got %h want %h", RX_BYTE, last_good); end
        total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL rand_exclusive: dv and ferr high together"); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_baud_skew();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
